// File: rtl/cva6_sb_model_if.sv
// Store-buffer model bundle: issue, commit, memory-request and status signals.
// Clock and reset stay as plain ports on the module.
interface cva6_sb_model_if #(
  parameter int unsigned SPEC_DEPTH   = 4,
  parameter int unsigned COMMIT_DEPTH = 4,
  parameter int unsigned ADDR_W       = 34,
  parameter int unsigned DATA_W       = 32
);
  localparam int unsigned SCW = $clog2(SPEC_DEPTH + 1);
  localparam int unsigned CCW = $clog2(COMMIT_DEPTH + 1);

  logic              flush_i;
  logic              instr_valid_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  logic              commit_i;
  logic              commit_ready_o;
  logic              store_mem_resp_i;
  logic              mem_req_valid_o;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic [DATA_W-1:0] mem_req_data_o;
  logic              pop_st_o;
  logic [11:0]       page_offset_i;
  logic              page_offset_matches_o;
  logic [SCW-1:0]    spec_cnt_o;
  logic [CCW-1:0]    commit_cnt_o;
  logic              no_st_pending_o;
  logic              store_buffer_empty_o;
  logic              err_o;

  modport master (
    output flush_i, instr_valid_i, addr_i, data_i, commit_i, store_mem_resp_i, page_offset_i,
    input  ready_o, commit_ready_o, mem_req_valid_o, mem_req_addr_o, mem_req_data_o, pop_st_o,
           page_offset_matches_o, spec_cnt_o, commit_cnt_o, no_st_pending_o,
           store_buffer_empty_o, err_o
  );

  modport slave (
    input  flush_i, instr_valid_i, addr_i, data_i, commit_i, store_mem_resp_i, page_offset_i,
    output ready_o, commit_ready_o, mem_req_valid_o, mem_req_addr_o, mem_req_data_o, pop_st_o,
           page_offset_matches_o, spec_cnt_o, commit_cnt_o, no_st_pending_o,
           store_buffer_empty_o, err_o
  );
endinterface

// File: rtl/cva6_sb_model.sv
// Cycle-level CVA6 store buffer model: a speculative FIFO feeding a commit FIFO
// that drains on memory grants, with flush, page-offset matching and sticky error.
module cva6_sb_model #(
  parameter int unsigned SPEC_DEPTH   = 4,
  parameter int unsigned COMMIT_DEPTH = 4,
  parameter int unsigned ADDR_W       = 34,
  parameter int unsigned DATA_W       = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  cva6_sb_model_if.slave  sb
);
  localparam int unsigned SPW = $clog2(SPEC_DEPTH);
  localparam int unsigned CPW = $clog2(COMMIT_DEPTH);
  localparam int unsigned SCW = $clog2(SPEC_DEPTH + 1);
  localparam int unsigned CCW = $clog2(COMMIT_DEPTH + 1);
  localparam logic [SCW-1:0] SPEC_FULL   = SCW'(SPEC_DEPTH);
  localparam logic [CCW-1:0] COMMIT_FULL = CCW'(COMMIT_DEPTH);

  logic [ADDR_W-1:0] spec_addr   [SPEC_DEPTH];
  logic [DATA_W-1:0] spec_data   [SPEC_DEPTH];
  logic [ADDR_W-1:0] commit_addr [COMMIT_DEPTH];
  logic [DATA_W-1:0] commit_data [COMMIT_DEPTH];

  logic [SPW-1:0] spec_rptr, spec_wptr;
  logic [CPW-1:0] commit_rptr, commit_wptr;
  logic [SCW-1:0] spec_cnt;
  logic [CCW-1:0] commit_cnt;
  logic           err_q, pop_st_q;

  logic spec_full, spec_empty, commit_full, commit_empty;
  logic push, commit, grant, err_set;
  logic match;
  logic [SPW-1:0] spec_offs;
  logic [CPW-1:0] commit_offs;

  always_comb begin
    spec_full    = (spec_cnt == SPEC_FULL);
    spec_empty   = (spec_cnt == '0);
    commit_full  = (commit_cnt == COMMIT_FULL);
    commit_empty = (commit_cnt == '0);
    // Flush wins over push/commit and also masks their error conditions.
    push    = sb.instr_valid_i & ~spec_full & ~sb.flush_i;
    commit  = sb.commit_i & ~commit_full & ~spec_empty & ~sb.flush_i;
    grant   = sb.store_mem_resp_i & ~commit_empty;
    err_set = (sb.instr_valid_i & spec_full & ~sb.flush_i)
            | (sb.commit_i & ~sb.flush_i & (spec_empty | commit_full))
            | (sb.store_mem_resp_i & commit_empty);
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      spec_addr[spec_wptr] <= sb.addr_i;
      spec_data[spec_wptr] <= sb.data_i;
    end
    if (commit) begin
      commit_addr[commit_wptr] <= spec_addr[spec_rptr];
      commit_data[commit_wptr] <= spec_data[spec_rptr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spec_rptr   <= '0;
      spec_wptr   <= '0;
      spec_cnt    <= '0;
      commit_rptr <= '0;
      commit_wptr <= '0;
      commit_cnt  <= '0;
      err_q       <= 1'b0;
      pop_st_q    <= 1'b0;
    end else begin
      err_q    <= err_q | err_set;
      pop_st_q <= push;
      if (sb.flush_i) begin
        spec_cnt  <= '0;
        spec_rptr <= spec_wptr;
      end else begin
        if (push)   spec_wptr <= spec_wptr + SPW'(1);
        if (commit) spec_rptr <= spec_rptr + SPW'(1);
        spec_cnt <= spec_cnt + SCW'(push) - SCW'(commit);
      end
      if (commit) commit_wptr <= commit_wptr + CPW'(1);
      if (grant)  commit_rptr <= commit_rptr + CPW'(1);
      commit_cnt <= commit_cnt + CCW'(commit) - CCW'(grant);
    end
  end

  // An entry is valid when its distance from the read pointer is below the count.
  always_comb begin
    match       = 1'b0;
    spec_offs   = '0;
    commit_offs = '0;
    for (int unsigned i = 0; i < SPEC_DEPTH; i++) begin
      spec_offs = SPW'(i) - spec_rptr;
      if ((SCW'(spec_offs) < spec_cnt) &&
          (spec_addr[i][11:3] == sb.page_offset_i[11:3]))
        match = 1'b1;
    end
    for (int unsigned i = 0; i < COMMIT_DEPTH; i++) begin
      commit_offs = CPW'(i) - commit_rptr;
      if ((CCW'(commit_offs) < commit_cnt) &&
          (commit_addr[i][11:3] == sb.page_offset_i[11:3]))
        match = 1'b1;
    end
  end

  logic unused_page_lsbs;
  assign unused_page_lsbs = ^sb.page_offset_i[2:0];

  assign sb.ready_o               = ~spec_full;
  assign sb.commit_ready_o        = ~commit_full;
  assign sb.mem_req_valid_o       = ~commit_empty;
  assign sb.mem_req_addr_o        = commit_addr[commit_rptr];
  assign sb.mem_req_data_o        = commit_data[commit_rptr];
  assign sb.pop_st_o              = pop_st_q;
  assign sb.page_offset_matches_o = match;
  assign sb.spec_cnt_o            = spec_cnt;
  assign sb.commit_cnt_o          = commit_cnt;
  assign sb.no_st_pending_o       = commit_empty;
  assign sb.store_buffer_empty_o  = commit_empty & spec_empty;
  assign sb.err_o                 = err_q;
endmodule

// File: tb/tb_cva6_sb_model.sv
// Bench for cva6_sb_model: directed scenarios then random traffic, compared every
// cycle against a queue-based reference of the store buffer.
module tb_cva6_sb_model;
  localparam int unsigned SD = 4;
  localparam int unsigned CD = 4;
  localparam int unsigned AW = 34;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cva6_sb_model_if #(.SPEC_DEPTH(SD), .COMMIT_DEPTH(CD), .ADDR_W(AW), .DATA_W(DW)) sb_if ();

  cva6_sb_model #(.SPEC_DEPTH(SD), .COMMIT_DEPTH(CD), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb    (sb_if)
  );

  int errors = 0;
  int checks = 0;

  entry_t spec_q[$];
  entry_t com_q[$];
  bit     m_err = 1'b0;
  bit     m_pop = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_match(input logic [11:0] po);
    bit m = 1'b0;
    foreach (spec_q[i]) if (spec_q[i].addr[11:3] == po[11:3]) m = 1'b1;
    foreach (com_q[i])  if (com_q[i].addr[11:3] == po[11:3]) m = 1'b1;
    return m;
  endfunction

  task automatic model_step();
    bit sfull, cfull, push_ok, commit_ok, grant_ok;
    entry_t e;
    if (rst) begin
      spec_q.delete();
      com_q.delete();
      m_err = 1'b0;
      m_pop = 1'b0;
      return;
    end
    sfull     = (spec_q.size() == SD);
    cfull     = (com_q.size() == CD);
    push_ok   = sb_if.instr_valid_i && !sfull && !sb_if.flush_i;
    commit_ok = sb_if.commit_i && !sb_if.flush_i && spec_q.size() > 0 && !cfull;
    grant_ok  = sb_if.store_mem_resp_i && com_q.size() > 0;
    if ((sb_if.instr_valid_i && sfull && !sb_if.flush_i) ||
        (sb_if.commit_i && !sb_if.flush_i && (spec_q.size() == 0 || cfull)) ||
        (sb_if.store_mem_resp_i && com_q.size() == 0))
      m_err = 1'b1;
    m_pop = push_ok;
    if (grant_ok) void'(com_q.pop_front());
    if (commit_ok) begin
      e = spec_q.pop_front();
      com_q.push_back(e);
    end
    if (push_ok) spec_q.push_back('{addr: sb_if.addr_i, data: sb_if.data_i});
    if (sb_if.flush_i) spec_q.delete();
  endtask

  task automatic compare_all();
    check("spec_cnt", 64'(sb_if.spec_cnt_o), 64'(spec_q.size()));
    check("commit_cnt", 64'(sb_if.commit_cnt_o), 64'(com_q.size()));
    check("ready", 64'(sb_if.ready_o), 64'(spec_q.size() != SD));
    check("commit_ready", 64'(sb_if.commit_ready_o), 64'(com_q.size() != CD));
    check("mem_req_valid", 64'(sb_if.mem_req_valid_o), 64'(com_q.size() != 0));
    check("no_st_pending", 64'(sb_if.no_st_pending_o), 64'(com_q.size() == 0));
    check("sb_empty", 64'(sb_if.store_buffer_empty_o),
          64'(com_q.size() == 0 && spec_q.size() == 0));
    check("err", 64'(sb_if.err_o), 64'(m_err));
    check("pop_st", 64'(sb_if.pop_st_o), 64'(m_pop));
    check("match", 64'(sb_if.page_offset_matches_o), 64'(m_match(sb_if.page_offset_i)));
    if (com_q.size() != 0) begin
      check("mem_req_addr", 64'(sb_if.mem_req_addr_o), 64'(com_q[0].addr));
      check("mem_req_data", 64'(sb_if.mem_req_data_o), 64'(com_q[0].data));
    end
  endtask

  task automatic tick(input bit iv, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit cm, input bit gr, input bit fl, input logic [11:0] po);
    sb_if.instr_valid_i    = iv;
    sb_if.addr_i           = a;
    sb_if.data_i           = d;
    sb_if.commit_i         = cm;
    sb_if.store_mem_resp_i = gr;
    sb_if.flush_i          = fl;
    sb_if.page_offset_i    = po;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic [11:0] po);
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, po);
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tick(1'b1, a, d, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) idle(12'h000);
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] offs [4];
    logic [11:0] po;
    offs[0] = 12'hA48; offs[1] = 12'h100; offs[2] = 12'h7F8; offs[3] = 12'h008;

    // reset and idle
    do_reset(2);
    check("rst_spec_cnt", 64'(sb_if.spec_cnt_o), 64'd0);
    check("rst_ready", 64'(sb_if.ready_o), 64'd1);
    check("rst_empty", 64'(sb_if.store_buffer_empty_o), 64'd1);
    check("rst_err", 64'(sb_if.err_o), 64'd0);

    // single store end-to-end
    push(34'h0_1234_5678, 32'hDEADBEEF);
    check("single_spec", 64'(sb_if.spec_cnt_o), 64'd1);
    check("single_pop", 64'(sb_if.pop_st_o), 64'd1);
    tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 12'h000);
    check("single_valid", 64'(sb_if.mem_req_valid_o), 64'd1);
    check("single_addr", 64'(sb_if.mem_req_addr_o), 64'h0_1234_5678);
    check("single_data", 64'(sb_if.mem_req_data_o), 64'hDEADBEEF);
    tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 12'h000);
    check("single_done", 64'(sb_if.store_buffer_empty_o), 64'd1);
    check("single_nsp", 64'(sb_if.no_st_pending_o), 64'd1);

    // fill, overflow, drain, then wrap
    for (int i = 0; i < 5; i++) begin
      push({22'(i + 1), 12'h100}, 32'hA000_0000 + 32'(i));
      if (i == 3) check("fill_ready", 64'(sb_if.ready_o), 64'd0);
    end
    check("fill_err", 64'(sb_if.err_o), 64'd1);
    check("fill_cnt", 64'(sb_if.spec_cnt_o), 64'd4);
    for (int i = 0; i < 4; i++) tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < 4; i++) begin
      check("fill_order", 64'(sb_if.mem_req_data_o), 64'(32'hA000_0000 + 32'(i)));
      tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 12'h000);
    end
    for (int i = 0; i < 4; i++) push({22'(i + 9), 12'h100}, 32'hB000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < 4; i++) begin
      check("wrap_order", 64'(sb_if.mem_req_data_o), 64'(32'hB000_0000 + 32'(i)));
      tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 12'h000);
    end

    // flush with a coincident commit
    do_reset(1);
    push(34'h1000, 32'h1111_0000);
    push(34'h2000, 32'h2222_0000);
    tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 12'h000);
    push(34'h3000, 32'h3333_0000);
    tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 12'h000);
    check("flush_spec", 64'(sb_if.spec_cnt_o), 64'd0);
    check("flush_commit", 64'(sb_if.commit_cnt_o), 64'd1);
    check("flush_err", 64'(sb_if.err_o), 64'd0);
    check("flush_head", 64'(sb_if.mem_req_data_o), 64'h1111_0000);
    tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 12'h000);
    check("flush_drain", 64'(sb_if.commit_cnt_o), 64'd0);

    // push, commit and grant together
    for (int i = 0; i < 4; i++) push({22'(i + 20), 12'h200}, 32'hC000_0000 + 32'(i));
    tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 12'h000);
    tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 12'h000);
    tick(1'b1, {22'd30, 12'h200}, 32'hC000_0004, 1'b1, 1'b1, 1'b0, 12'h000);
    check("simul_spec", 64'(sb_if.spec_cnt_o), 64'd2);
    check("simul_commit", 64'(sb_if.commit_cnt_o), 64'd2);
    check("simul_head", 64'(sb_if.mem_req_data_o), 64'hC000_0001);
    for (int i = 0; i < 2; i++) tick(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 12'h000);
    for (int i = 0; i < 2; i++) tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 12'h000);
    check("simul_empty", 64'(sb_if.store_buffer_empty_o), 64'd1);

    // page-offset match
    push(34'h0_0000_0A48, 32'h5A5A_5A5A);
    idle(12'hA4C);
    check("match_hit", 64'(sb_if.page_offset_matches_o), 64'd1);
    idle(12'hA50);
    check("match_miss", 64'(sb_if.page_offset_matches_o), 64'd0);
    tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 12'hA4C);
    check("match_commitq", 64'(sb_if.page_offset_matches_o), 64'd1);
    tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 12'hA4C);
    check("match_retired", 64'(sb_if.page_offset_matches_o), 64'd0);

    // random traffic
    do_reset(1);
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      po  = offs[$urandom_range(0, 3)] | 12'($urandom_range(0, 7));
      tick(1'($urandom_range(0, 99) < 55),
           {22'($urandom), offs[$urandom_range(0, 3)]},
           32'($urandom),
           1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 40),
           1'($urandom_range(0, 99) < 6),
           po);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
